// File: rtl/path_anim_controller_if.sv
// Bundles the animation controls and renderer-facing outputs of path_anim_controller.
// The master side drives the controls. The slave side is the controller.
interface path_anim_controller_if #(
    parameter int POS_W = 7
);
    logic             enable;
    logic             start_btn;
    logic             anim_tick;
    logic [1:0]       speed;
    logic [2:0]       seg_idx;
    logic [POS_W-1:0] seg_pos;
    logic             busy;
    logic             done;
    logic             seg_adv;

    modport master (
        output enable, start_btn, anim_tick, speed,
        input  seg_idx, seg_pos, busy, done, seg_adv
    );

    modport slave (
        input  enable, start_btn, anim_tick, speed,
        output seg_idx, seg_pos, busy, done, seg_adv
    );
endinterface

// File: rtl/path_anim_controller.sv
// Growing-path animation sequencer: gates on unlock, starts on button release,
// and grows a six-segment path one tick at a time for the pixel renderer.
module path_anim_controller #(
    parameter int NUM_SEG = 6,
    parameter int POS_W   = 7
) (
    input  logic                   sixp25MHz_clock,
    input  logic                   rst_n,
    path_anim_controller_if.slave  io
);
    typedef enum logic [1:0] {LOCKED, IDLE, RUN, HOLD} state_e;

    state_e           state_q;
    logic [2:0]       seg_idx_q;
    logic [POS_W-1:0] seg_pos_q;
    logic             busy_q, done_q, seg_adv_q;

    // [0],[1] are the synchronizer stages, [2] is the last-value register.
    logic [2:0] btn_pipe_q, tick_pipe_q;
    logic       btn_fall, tick_rise;

    logic [POS_W-1:0] seg_last_d;
    logic [1:0]       step_d;
    logic [POS_W:0]   pos_sum_d;
    logic [POS_W-1:0] pos_next_d;

    assign btn_fall  =  btn_pipe_q[2]  & ~btn_pipe_q[1];
    assign tick_rise = ~tick_pipe_q[2] &  tick_pipe_q[1];

    // Last valid position within the active segment (length minus one).
    always_comb begin
        seg_last_d = POS_W'(13);
        case (seg_idx_q)
            3'd0:    seg_last_d = POS_W'(40);
            3'd1:    seg_last_d = POS_W'(41);
            3'd2:    seg_last_d = POS_W'(25);
            3'd3:    seg_last_d = POS_W'(20);
            3'd4:    seg_last_d = POS_W'(36);
            default: seg_last_d = POS_W'(13);
        endcase
    end

    // One extra bit on the add so a large step near the end cannot wrap.
    always_comb begin
        step_d     = (io.speed == 2'd0) ? 2'd1 : io.speed;
        pos_sum_d  = {1'b0, seg_pos_q} + (POS_W+1)'(step_d);
        pos_next_d = (pos_sum_d > {1'b0, seg_last_d}) ? seg_last_d
                                                      : pos_sum_d[POS_W-1:0];
    end

    always_ff @(posedge sixp25MHz_clock or negedge rst_n) begin
        if (!rst_n) begin
            btn_pipe_q  <= '0;
            tick_pipe_q <= '0;
            state_q     <= LOCKED;
            seg_idx_q   <= '0;
            seg_pos_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seg_adv_q   <= 1'b0;
        end else begin
            btn_pipe_q  <= {btn_pipe_q[1:0],  io.start_btn};
            tick_pipe_q <= {tick_pipe_q[1:0], io.anim_tick};
            seg_adv_q   <= 1'b0;
            if (!io.enable) begin
                state_q   <= LOCKED;
                seg_idx_q <= '0;
                seg_pos_q <= '0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    LOCKED: state_q <= IDLE;
                    IDLE: if (btn_fall) begin
                        state_q   <= RUN;
                        seg_idx_q <= '0;
                        seg_pos_q <= '0;
                        busy_q    <= 1'b1;
                    end
                    // Button edges are deliberately ignored while running.
                    RUN: if (tick_rise) begin
                        if (seg_pos_q == seg_last_d) begin
                            seg_adv_q <= 1'b1;
                            if (seg_idx_q == 3'(NUM_SEG-1)) begin
                                state_q <= HOLD;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                seg_idx_q <= seg_idx_q + 3'd1;
                                seg_pos_q <= '0;
                            end
                        end else begin
                            seg_pos_q <= pos_next_d;
                        end
                    end
                    HOLD: if (btn_fall) begin
                        state_q   <= RUN;
                        seg_idx_q <= '0;
                        seg_pos_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                    default: state_q <= LOCKED;
                endcase
            end
        end
    end

    assign io.seg_idx = seg_idx_q;
    assign io.seg_pos = seg_pos_q;
    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.seg_adv = seg_adv_q;
endmodule

// File: tb/tb_path_anim_controller.sv
// Randomized event-level bench for path_anim_controller against a path-progress model.
module tb_path_anim_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   adv_cnt = 0;

    path_anim_controller_if #(.POS_W(7)) io ();
    path_anim_controller #(.NUM_SEG(6), .POS_W(7)) dut (
        .sixp25MHz_clock(clk),
        .rst_n(rst_n),
        .io(io)
    );

    always #80 clk = ~clk;

    // seg_adv is a single-cycle pulse, so each pulse is seen on exactly one falling edge.
    always @(negedge clk) if (io.seg_adv === 1'b1) adv_cnt++;

    // Model: 0 locked, 1 idle, 2 running, 3 holding the finished path.
    int L[6] = '{41, 42, 26, 21, 37, 14};
    int m_mode, m_idx, m_pos, m_adv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".idx"},  32'(io.seg_idx), 32'(m_idx));
        chk({tag, ".pos"},  32'(io.seg_pos), 32'(m_pos));
        chk({tag, ".busy"}, 32'(io.busy),    32'(m_mode == 2));
        chk({tag, ".done"}, 32'(io.done),    32'(m_mode == 3));
        chk({tag, ".adv"},  32'(adv_cnt),    32'(m_adv));
    endtask

    function automatic void m_tick(input int spd);
        int step = (spd == 0) ? 1 : spd;
        if (m_mode != 2) return;
        if (m_pos == L[m_idx] - 1) begin
            m_adv++;
            if (m_idx == 5) m_mode = 3;
            else begin m_idx++; m_pos = 0; end
        end else begin
            m_pos = (m_pos + step > L[m_idx] - 1) ? L[m_idx] - 1 : m_pos + step;
        end
    endfunction

    function automatic void m_release();
        if (m_mode == 1 || m_mode == 3) begin m_mode = 2; m_idx = 0; m_pos = 0; end
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_evt(input int spd, input string tag);
        io.speed = 2'(spd); io.anim_tick = 1'b1; wait_n(4);
        io.anim_tick = 1'b0; wait_n(4);
        m_tick(spd);
        chk_all(tag);
    endtask

    task automatic btn_evt(input string tag);
        io.start_btn = 1'b1; wait_n(4);
        io.start_btn = 1'b0; wait_n(4);
        m_release();
        chk_all(tag);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        io.enable = 1'b0; io.start_btn = 1'b0; io.anim_tick = 1'b0; io.speed = 2'd0;
        m_mode = 0; m_idx = 0; m_pos = 0; m_adv = 0;
        wait_n(3);
        chk_all("reset");
        chk("reset.seg_adv", 32'(io.seg_adv), 32'd0);
        rst_n = 1'b1;
        wait_n(2);

        // Locked: button and ticks have no effect.
        btn_evt("locked_btn");
        tick_evt(1, "locked_tick");

        io.enable = 1'b1; wait_n(2); m_mode = 1;
        chk_all("unlock_idle");

        // Release timing: busy on the 3rd rising edge after first sample.
        io.start_btn = 1'b1; wait_n(4);
        io.start_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("lat2.busy", 32'(io.busy), 32'd0);
        @(posedge clk);
        #1 chk("lat3.busy", 32'(io.busy), 32'd1);
        wait_n(3); m_release();

        // Full run at speed 1.
        n = 0;
        while (m_mode == 2 && n < 400) begin
            tick_evt(1, "run1"); n++;
            if (n == 41) begin
                chk("run1_t41.idx", 32'(io.seg_idx), 32'd1);
                chk("run1_t41.pos", 32'(io.seg_pos), 32'd0);
                chk("run1_t41.adv", 32'(adv_cnt), 32'd1);
            end
        end
        chk("run1.ticks", 32'(n), 32'd181);
        chk("run1.done", 32'(io.done), 32'd1);
        chk("run1.idx", 32'(io.seg_idx), 32'd5);
        chk("run1.pos", 32'(io.seg_pos), 32'd13);
        chk("run1.adv", 32'(adv_cnt), 32'd6);
        tick_evt(2, "hold_tick");

        // Restart from HOLD with a tick rising in the same cycle.
        io.start_btn = 1'b1; wait_n(4);
        io.start_btn = 1'b0; io.anim_tick = 1'b1; io.speed = 2'd3; wait_n(4);
        io.anim_tick = 1'b0; wait_n(4);
        m_release();
        chk_all("restart_tick");
        chk("restart.pos", 32'(io.seg_pos), 32'd0);

        // Speed 3 through segment 0: clamps at 40, advances on 15th tick.
        for (int t = 1; t <= 15; t++) begin
            tick_evt(3, "spd3");
            if (t == 14) chk("spd3_t14.pos", 32'(io.seg_pos), 32'd40);
        end
        chk("spd3_t15.idx", 32'(io.seg_idx), 32'd1);

        // Button release mid-run is ignored.
        n = 0;
        while (!(m_idx == 2 && m_pos == 10) && n < 200) begin tick_evt(1, "to_2_10"); n++; end
        btn_evt("btn_in_run");
        chk("btn_in_run.idx", 32'(io.seg_idx), 32'd2);
        chk("btn_in_run.pos", 32'(io.seg_pos), 32'd10);

        // Random speeds into segment 3, then drop enable.
        n = 0;
        while (m_idx != 3 && n < 200) begin tick_evt($urandom_range(0, 3), "rnd_to3"); n++; end
        io.enable = 1'b0;
        @(posedge clk);
        #1 m_mode = 0; m_idx = 0; m_pos = 0;
        chk_all("lock_drop");
        io.enable = 1'b1; wait_n(3); m_mode = 1;
        chk_all("relock_idle");

        // Random mix of ticks and ignored button releases to completion.
        btn_evt("rnd_start");
        n = 0;
        while (m_mode == 2 && n < 600) begin
            if ($urandom_range(0, 4) == 0) btn_evt("rnd_btn");
            else tick_evt($urandom_range(0, 3), "rnd_tick");
            n++;
        end
        chk("rnd.done", 32'(io.done), 32'd1);

        // Asynchronous reset mid-run with the button and tick held high.
        btn_evt("pre_rst_start");
        tick_evt(2, "pre_rst_tick");
        tick_evt(3, "pre_rst_tick");
        io.start_btn = 1'b1; io.anim_tick = 1'b1;
        @(negedge clk); #37 rst_n = 1'b0;
        #1 m_mode = 0; m_idx = 0; m_pos = 0;
        chk_all("async_rst");
        wait_n(2); rst_n = 1'b1;
        wait_n(6); m_mode = 1;
        chk_all("post_rst_held");
        io.anim_tick = 1'b0; wait_n(4);
        btn_evt("post_rst_start");
        tick_evt(0, "post_rst_tick0");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/path_anim_controller.md
# path_anim_controller

Sequencer for the OLED "growing path" animation. Owns the animation state: unlock gating, start/restart on push-button release, and per-tick growth of a fixed six-segment path. It publishes the active segment index and its growth position to the pixel renderer, which draws all completed segments fully and the active segment up to `seg_pos`. It does no pixel drawing itself.

## Interface
Parameters
- `NUM_SEG`, default 6: number of path segments. Valid range is 1–6, limited by the length table.
- `POS_W`, default 7: width of the position counter. It must hold the longest segment length minus 1.

Ports
- `sixp25MHz_clock`  in  1: system clock, 6.25 MHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: unlock condition, already decoded from SW. Synchronous level.
- `start_btn`  in  1: raw push-button level. Asynchronous.
- `anim_tick`  in  1: slow animation clock, about 45 Hz, treated as an asynchronous level.
- `speed`  in  2: growth step per tick. A value of 0 is treated as 1.
- `seg_idx`  out  3: active segment, 0..NUM_SEG-1.
- `seg_pos`  out  POS_W: pixels grown within the active segment, 0..L[seg_idx]-1.
- `busy`  out  1: high in RUN.
- `done`  out  1: high in HOLD.
- `seg_adv`  out  1: one-cycle pulse when `seg_idx` increments or the path completes.

## Operation
- **Segment length table L** (pixels, fixed ROM): {41, 42, 26, 21, 37, 14}, giving a total of 181.
- **Input conditioning:** `start_btn` and `anim_tick` each pass through a 2-flop synchronizer followed by a last-value register.
  - `btn_fall` = last & ~sync2.
  - `tick_rise` = ~last & sync2.
- **FSM states:** LOCKED, IDLE, RUN, HOLD. Priority within a cycle is lock > start > tick.
  - Any state with `enable`=0 goes to LOCKED. This clears `seg_idx` and `seg_pos` and drops `busy` and `done`.
  - LOCKED with `enable`=1 goes to IDLE.
  - IDLE with `btn_fall` goes to RUN, with `seg_idx`=0 and `seg_pos`=0.
  - RUN with `tick_rise`:
    - If `seg_pos` = L[seg_idx]-1 and this is the last segment: go to HOLD and pulse `seg_adv`. `seg_idx` and `seg_pos` keep their final values.
    - If `seg_pos` = L[seg_idx]-1 and this is not the last segment: increment `seg_idx`, set `seg_pos` to 0, pulse `seg_adv`.
    - Otherwise: `seg_pos` = min(seg_pos + step, L[seg_idx]-1), where step = (speed==0) ? 1 : speed. Compute the add at POS_W+1 bits so it cannot wrap.
  - RUN with `btn_fall`: ignored. There is no mid-run restart.
  - HOLD with `btn_fall` goes to RUN with `seg_idx`=0 and `seg_pos`=0. A tick in the same cycle is ignored.
- **Speed changes:** `speed` is sampled only on `tick_rise`. A change mid-segment takes effect on the next tick.
- **Outputs:** all are registered. `busy` and `done` decode the registered state.

## Timing
- **Reset values:**
  - State is LOCKED.
  - `seg_idx`=0, `seg_pos`=0, `busy`=0, `done`=0, `seg_adv`=0.
  - All synchronizer and last-value flops are 0, so a button held high through reset release produces no edge.
- **Input latency:** a transition on `start_btn` or `anim_tick` changes the outputs on the 3rd rising clock edge after it is first sampled. That is 2 synchronizer stages plus 1 edge/state register.
- **`enable` latency:** `enable` is not synchronized. Going to LOCKED takes 1 clock edge.
- **Ticks to complete:** each segment takes ceil((L-1)/step)+1 tick rises, the last of which is the advance tick. At speed 1, completion takes 181 tick rises after start, about 4.0 s at 45 Hz.
- **`seg_adv`:** high for exactly one clock, coincident with the `seg_idx` or state update.
- **Reset mid-RUN:** immediate asynchronous return to the reset values. No edge is detected on the first post-reset cycles.

## Test plan
- **Reset and lock:** assert `rst_n`=0 mid-RUN. Expect all outputs at reset values immediately. With `enable`=0, button presses leave the state in LOCKED.
- **Full run at speed 1:** `enable`=1, then release the button.
  - `busy` rises 3 clocks later.
  - After 41 ticks: `seg_idx`=1, `seg_pos`=0, one `seg_adv` pulse.
  - After 181 ticks: `done`=1, `seg_idx`=5, `seg_pos`=13, 6 `seg_adv` pulses in total.
- **Speed 3, segment 0:** `seg_pos` follows 0,3,…,39,40. `seg_idx` becomes 1 on the 15th tick, with no overshoot past 40.
- **Restart from HOLD:** release the button in HOLD. Expect `seg_idx`=0, `seg_pos`=0, `busy`=1. A tick and a button edge in the same cycle give a restart with no position increment.
- **Button during RUN:** release the button at `seg_idx`=2, `seg_pos`=10. Position and index continue unchanged.
- **Unlock drop:** drop `enable` at `seg_idx`=3. Expect LOCKED with `seg_idx`=`seg_pos`=0 next clock. Raising `enable` again gives IDLE, not RUN.
